// File: rtl/pleasure_pkg.sv
// Types shared by the affect-state blocks. The mood classification is also the
// state encoding of the mood FSM in pleasure_state.
package pleasure_pkg;

    typedef enum logic [1:0] {
        MOOD_NEUTRAL = 2'b00,
        MOOD_SAD     = 2'b01,
        MOOD_HAPPY   = 2'b10
    } mood_t;

endpackage

// File: rtl/pleasure_state_if.sv
// Bundle between the pleasure regulator (master) and pleasure_state (slave):
// step requests in, and the integrated level and mood out.
interface pleasure_state_if #(
    parameter int WIDTH = 8
);
    import pleasure_pkg::*;

    // Handshake: tick is a one-way update strobe with no ready. On every clock
    // where tick=1, the slave consumes pleasure_inc/pleasure_dec. There is no
    // backpressure. The outputs are registered and are valid on every cycle.
    logic             tick;
    logic             pleasure_inc;
    logic             pleasure_dec;
    logic [WIDTH-1:0] level;
    mood_t            mood;
    logic             level_changed;
    logic             saturated;

    modport master (
        output tick, pleasure_inc, pleasure_dec,
        input  level, mood, level_changed, saturated
    );

    modport slave (
        input  tick, pleasure_inc, pleasure_dec,
        output level, mood, level_changed, saturated
    );

endinterface

// File: rtl/pleasure_state_sat_updown_counter.sv
// Saturating up/down counter. It keeps one guard bit so that +1 at max and
// -1 at zero clamp and never wrap. The at_min and at_max flags are registered
// together with q.
module sat_updown_counter #(
    parameter int WIDTH = 8,
    parameter int INIT  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             down,
    output logic [WIDTH-1:0] q,
    output logic             at_min,
    output logic             at_max
);

    localparam logic [WIDTH:0]   MAX_EXT = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0]   ONE_EXT = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] INIT_L  = WIDTH'(INIT);

    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] next_ext;

    always_comb begin
        q_ext    = {1'b0, q};
        next_ext = q_ext;
        if (en && up && !down && (q_ext != MAX_EXT)) begin
            next_ext = q_ext + ONE_EXT;
        end else if (en && down && !up && (q_ext != '0)) begin
            next_ext = q_ext - ONE_EXT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q      <= INIT_L;
            at_min <= (INIT_L == '0);
            at_max <= (INIT_L == '1);
        end else begin
            q      <= next_ext[WIDTH-1:0];
            at_min <= (next_ext == '0);
            at_max <= (next_ext == MAX_EXT);
        end
    end

endmodule

// File: rtl/pleasure_state.sv
// Integrates the pleasure steps into a saturating level. The level drifts back
// toward INIT when ticks are idle, and it is classified into a mood with hysteresis.
module pleasure_state
    import pleasure_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int INIT         = 128,
    parameter int DECAY_PERIOD = 64,
    parameter int LOW_TH       = 64,
    parameter int HIGH_TH      = 192,
    parameter int HYST         = 8
) (
    input  logic             clk,
    input  logic             rst,
    pleasure_state_if.slave  bus
);

    localparam int               IDLE_W    = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(DECAY_PERIOD - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
    localparam logic [WIDTH-1:0] INIT_L    = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] LOW_L     = WIDTH'(LOW_TH);
    localparam logic [WIDTH-1:0] HIGH_L    = WIDTH'(HIGH_TH);
    localparam logic [WIDTH-1:0] SAD_EXIT  = WIDTH'(LOW_TH + HYST);
    localparam logic [WIDTH-1:0] HAPPY_EXIT = WIDTH'(HIGH_TH - HYST);

    logic [IDLE_W-1:0] idle_cnt;
    logic [WIDTH-1:0]  level;
    logic              at_min;
    logic              at_max;
    logic              idle_tick;
    logic              decay_due;
    logic              step_up;
    logic              step_down;
    logic              will_change;
    logic              level_changed;
    mood_t             mood;

    // When inc and dec are both set, or both clear, the tick is idle.
    assign idle_tick = (bus.pleasure_inc == bus.pleasure_dec);
    assign decay_due = idle_tick && (idle_cnt == IDLE_LAST);

    always_comb begin
        step_up   = 1'b0;
        step_down = 1'b0;
        if (!idle_tick) begin
            step_up   = bus.pleasure_inc;
            step_down = bus.pleasure_dec;
        end else if (decay_due) begin
            step_up   = (level < INIT_L);
            step_down = (level > INIT_L);
        end
    end

    assign will_change = bus.tick && ((step_up && !at_max) || (step_down && !at_min));

    sat_updown_counter #(
        .WIDTH (WIDTH),
        .INIT  (INIT)
    ) u_level (
        .clk    (clk),
        .rst    (rst),
        .en     (bus.tick),
        .up     (step_up),
        .down   (step_down),
        .q      (level),
        .at_min (at_min),
        .at_max (at_max)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt      <= '0;
            level_changed <= 1'b0;
        end else begin
            level_changed <= will_change;
            if (bus.tick) begin
                if (!idle_tick || decay_due) begin
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + IDLE_ONE;
                end
            end
        end
    end

    // The mood FSM looks at the registered level, so it trails level by one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mood <= MOOD_NEUTRAL;
        end else begin
            case (mood)
                MOOD_NEUTRAL: begin
                    if (level >= HIGH_L)     mood <= MOOD_HAPPY;
                    else if (level <= LOW_L) mood <= MOOD_SAD;
                end
                MOOD_HAPPY: begin
                    if (level < HAPPY_EXIT)  mood <= (level <= LOW_L) ? MOOD_SAD : MOOD_NEUTRAL;
                end
                MOOD_SAD: begin
                    if (level > SAD_EXIT)    mood <= (level >= HIGH_L) ? MOOD_HAPPY : MOOD_NEUTRAL;
                end
                default: mood <= MOOD_NEUTRAL;
            endcase
        end
    end

    assign bus.level         = level;
    assign bus.mood          = mood;
    assign bus.level_changed = level_changed;
    assign bus.saturated     = at_min | at_max;

endmodule

// File: tb/tb_pleasure_state.sv
// Bench for pleasure_state. Directed scenarios use DECAY_PERIOD=4.
// A randomized walk is checked against a rule-level reference model.
module tb_pleasure_state;
    import pleasure_pkg::*;

    localparam int WIDTH   = 8;
    localparam int INIT    = 128;
    localparam int DP      = 4;
    localparam int LOW_TH  = 64;
    localparam int HIGH_TH = 192;
    localparam int HYST    = 8;
    localparam int MAXV    = 255;

    logic  clk;
    logic  rst;
    int    n_checks;
    int    n_fail;

    int    m_level;
    int    m_idle;
    logic  m_changed;
    mood_t m_mood;
    logic [WIDTH-1:0] exp_q[$];

    pleasure_state_if #(.WIDTH(WIDTH)) bus ();

    pleasure_state #(
        .WIDTH(WIDTH), .INIT(INIT), .DECAY_PERIOD(DP),
        .LOW_TH(LOW_TH), .HIGH_TH(HIGH_TH), .HYST(HYST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic mood_t mood_rule(input mood_t m, input int lv);
        mood_t r;
        r = m;
        if (m == MOOD_NEUTRAL) begin
            if (lv >= HIGH_TH)     r = MOOD_HAPPY;
            else if (lv <= LOW_TH) r = MOOD_SAD;
        end else if (m == MOOD_HAPPY) begin
            if (lv < HIGH_TH - HYST) r = (lv <= LOW_TH) ? MOOD_SAD : MOOD_NEUTRAL;
        end else if (m == MOOD_SAD) begin
            if (lv > LOW_TH + HYST)  r = (lv >= HIGH_TH) ? MOOD_HAPPY : MOOD_NEUTRAL;
        end else begin
            r = MOOD_NEUTRAL;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_level   = INIT;
        m_idle    = 0;
        m_changed = 1'b0;
        m_mood    = MOOD_NEUTRAL;
    endtask

    // ---------------- driver ----------------
    // Drives one clock with the given inputs, advances the model, and returns 1 time unit after the edge.
    task automatic drive_cycle(input logic t, input logic i, input logic d);
        int    old;
        mood_t nm;
        bus.tick         = t;
        bus.pleasure_inc = i;
        bus.pleasure_dec = d;
        @(posedge clk);
        nm        = mood_rule(m_mood, m_level);
        m_changed = 1'b0;
        if (t) begin
            old = m_level;
            if (i && !d) begin
                m_level = (old < MAXV) ? old + 1 : MAXV;
                m_idle  = 0;
            end else if (d && !i) begin
                m_level = (old > 0) ? old - 1 : 0;
                m_idle  = 0;
            end else if (m_idle == DP - 1) begin
                m_idle = 0;
                if (old < INIT)      m_level = old + 1;
                else if (old > INIT) m_level = old - 1;
            end else begin
                m_idle = m_idle + 1;
            end
            m_changed = (m_level != old);
        end
        m_mood = nm;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.tick = 1'b0;
        bus.pleasure_inc = 1'b0;
        bus.pleasure_dec = 1'b0;
        #12;
        n_checks++; if (bus.level !== 8'd128) begin n_fail++; $display("FAIL reset_level got %0d exp 128", bus.level); end
        n_checks++; if (bus.mood !== MOOD_NEUTRAL) begin n_fail++; $display("FAIL reset_mood got %0d exp 0", bus.mood); end
        n_checks++; if (bus.level_changed !== 1'b0) begin n_fail++; $display("FAIL reset_changed got %0b exp 0", bus.level_changed); end
        n_checks++; if (bus.saturated !== 1'b0) begin n_fail++; $display("FAIL reset_saturated got %0b exp 0", bus.saturated); end
        rst = 1'b0;
        model_reset();
        repeat (22) drive_cycle(1'b1, 1'b1, 1'b0);
        n_checks++; if (bus.level !== 8'd150) begin n_fail++; $display("FAIL pre_reset_level got %0d exp 150", bus.level); end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.level !== 8'd128) begin n_fail++; $display("FAIL async_reset_level got %0d exp 128", bus.level); end
        n_checks++; if (bus.mood !== MOOD_NEUTRAL) begin n_fail++; $display("FAIL async_reset_mood got %0d exp 0", bus.mood); end
        n_checks++; if (bus.level_changed !== 1'b0) begin n_fail++; $display("FAIL async_reset_changed got %0b exp 0", bus.level_changed); end
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_inc_to_top();
        for (int i = 1; i <= 127; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b0);
            n_checks++; if (bus.level !== WIDTH'(128 + i)) begin n_fail++; $display("FAIL inc_level i=%0d got %0d exp %0d", i, bus.level, 128 + i); end
            n_checks++; if (bus.level_changed !== 1'b1) begin n_fail++; $display("FAIL inc_changed i=%0d got %0b exp 1", i, bus.level_changed); end
            n_checks++; if (bus.mood !== ((i >= 65) ? MOOD_HAPPY : MOOD_NEUTRAL)) begin n_fail++; $display("FAIL inc_mood i=%0d got %0d", i, bus.mood); end
        end
        n_checks++; if (bus.saturated !== 1'b1) begin n_fail++; $display("FAIL top_saturated got %0b exp 1", bus.saturated); end
        drive_cycle(1'b1, 1'b1, 1'b0);
        n_checks++; if (bus.level !== 8'd255) begin n_fail++; $display("FAIL top_hold_level got %0d exp 255", bus.level); end
        n_checks++; if (bus.level_changed !== 1'b0) begin n_fail++; $display("FAIL top_hold_changed got %0b exp 0", bus.level_changed); end
        n_checks++; if (bus.saturated !== 1'b1) begin n_fail++; $display("FAIL top_hold_saturated got %0b exp 1", bus.saturated); end
    endtask

    task automatic test_hysteresis();
        repeat (63) drive_cycle(1'b1, 1'b0, 1'b1);
        n_checks++; if (bus.level !== 8'd192) begin n_fail++; $display("FAIL hyst_start_level got %0d exp 192", bus.level); end
        repeat (7) drive_cycle(1'b1, 1'b0, 1'b1);
        n_checks++; if (bus.mood !== MOOD_HAPPY) begin n_fail++; $display("FAIL hyst_185_mood got %0d exp 2", bus.mood); end
        drive_cycle(1'b1, 1'b0, 1'b1);
        drive_cycle(1'b1, 1'b0, 1'b1);
        n_checks++; if (bus.level !== 8'd183) begin n_fail++; $display("FAIL hyst_183_level got %0d exp 183", bus.level); end
        n_checks++; if (bus.mood !== MOOD_HAPPY) begin n_fail++; $display("FAIL hyst_183_same_cycle_mood got %0d exp 2", bus.mood); end
        drive_cycle(1'b0, 1'b0, 1'b0);
        n_checks++; if (bus.mood !== MOOD_NEUTRAL) begin n_fail++; $display("FAIL hyst_183_next_mood got %0d exp 0", bus.mood); end
        repeat (8) drive_cycle(1'b1, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0);
        n_checks++; if (bus.level !== 8'd191) begin n_fail++; $display("FAIL hyst_191_level got %0d exp 191", bus.level); end
        n_checks++; if (bus.mood !== MOOD_NEUTRAL) begin n_fail++; $display("FAIL hyst_191_mood got %0d exp 0", bus.mood); end
        drive_cycle(1'b1, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0);
        n_checks++; if (bus.mood !== MOOD_HAPPY) begin n_fail++; $display("FAIL hyst_192_mood got %0d exp 2", bus.mood); end
    endtask

    task automatic test_decay();
        repeat (52) drive_cycle(1'b1, 1'b0, 1'b1);
        n_checks++; if (bus.level !== 8'd140) begin n_fail++; $display("FAIL decay_start got %0d exp 140", bus.level); end
        repeat (3) drive_cycle(1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.level !== 8'd140) begin n_fail++; $display("FAIL decay_tick3 got %0d exp 140", bus.level); end
        drive_cycle(1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.level !== 8'd139) begin n_fail++; $display("FAIL decay_tick4 got %0d exp 139", bus.level); end
        n_checks++; if (bus.level_changed !== 1'b1) begin n_fail++; $display("FAIL decay_changed got %0b exp 1", bus.level_changed); end
        repeat (4) drive_cycle(1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.level !== 8'd138) begin n_fail++; $display("FAIL decay_plus4 got %0d exp 138", bus.level); end
        repeat (4) drive_cycle(1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.level !== 8'd137) begin n_fail++; $display("FAIL decay_plus8 got %0d exp 137", bus.level); end
        drive_cycle(1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b0);
        repeat (3) drive_cycle(1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.level !== 8'd138) begin n_fail++; $display("FAIL decay_restart_hold got %0d exp 138", bus.level); end
        drive_cycle(1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.level !== 8'd137) begin n_fail++; $display("FAIL decay_restart_step got %0d exp 137", bus.level); end
        repeat (36) drive_cycle(1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.level !== 8'd128) begin n_fail++; $display("FAIL decay_to_init got %0d exp 128", bus.level); end
        repeat (8) drive_cycle(1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.level !== 8'd128) begin n_fail++; $display("FAIL decay_rest got %0d exp 128", bus.level); end
        n_checks++; if (bus.level_changed !== 1'b0) begin n_fail++; $display("FAIL decay_rest_changed got %0b exp 0", bus.level_changed); end
    endtask

    task automatic test_simultaneous();
        repeat (2) drive_cycle(1'b1, 1'b1, 1'b0);
        repeat (3) drive_cycle(1'b1, 1'b1, 1'b1);
        n_checks++; if (bus.level !== 8'd130) begin n_fail++; $display("FAIL both_hold got %0d exp 130", bus.level); end
        drive_cycle(1'b1, 1'b1, 1'b1);
        n_checks++; if (bus.level !== 8'd129) begin n_fail++; $display("FAIL both_decay got %0d exp 129", bus.level); end
    endtask

    task automatic test_bottom();
        repeat (65) drive_cycle(1'b1, 1'b0, 1'b1);
        drive_cycle(1'b0, 1'b0, 1'b0);
        n_checks++; if (bus.level !== 8'd64) begin n_fail++; $display("FAIL bottom_64_level got %0d exp 64", bus.level); end
        n_checks++; if (bus.mood !== MOOD_SAD) begin n_fail++; $display("FAIL bottom_64_mood got %0d exp 1", bus.mood); end
        repeat (64) drive_cycle(1'b1, 1'b0, 1'b1);
        n_checks++; if (bus.saturated !== 1'b1) begin n_fail++; $display("FAIL bottom_saturated got %0b exp 1", bus.saturated); end
        drive_cycle(1'b1, 1'b0, 1'b1);
        n_checks++; if (bus.level !== 8'd0) begin n_fail++; $display("FAIL bottom_hold got %0d exp 0", bus.level); end
        n_checks++; if (bus.level_changed !== 1'b0) begin n_fail++; $display("FAIL bottom_hold_changed got %0b exp 0", bus.level_changed); end
        repeat (72) drive_cycle(1'b1, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0);
        n_checks++; if (bus.mood !== MOOD_SAD) begin n_fail++; $display("FAIL bottom_72_mood got %0d exp 1", bus.mood); end
        drive_cycle(1'b1, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0);
        n_checks++; if (bus.mood !== MOOD_NEUTRAL) begin n_fail++; $display("FAIL bottom_73_mood got %0d exp 0", bus.mood); end
        for (int k = 0; k < 10; k++) begin
            drive_cycle(1'b0, 1'b1, 1'b0);
            n_checks++; if (bus.level !== 8'd73) begin n_fail++; $display("FAIL no_tick_level k=%0d got %0d exp 73", k, bus.level); end
        end
    endtask

    task automatic test_random();
        logic t;
        logic i;
        logic d;
        logic up_phase;
        int   r;
        logic [WIDTH-1:0] exp_level;
        for (int k = 0; k < 3500; k++) begin
            up_phase = (((k / 700) % 2) == 0);
            t = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r < 6)       begin i = up_phase;  d = !up_phase; end
            else if (r < 8)  begin i = !up_phase; d = up_phase;  end
            else if (r == 8) begin i = 1'b1;      d = 1'b1;      end
            else             begin i = 1'b0;      d = 1'b0;      end
            drive_cycle(t, i, d);
            exp_q.push_back(WIDTH'(m_level));
            exp_level = exp_q.pop_front();
            n_checks++; if (bus.level !== exp_level) begin n_fail++; $display("FAIL rnd_level k=%0d got %0d exp %0d", k, bus.level, exp_level); end
            n_checks++; if (bus.mood !== m_mood) begin n_fail++; $display("FAIL rnd_mood k=%0d got %0d exp %0d", k, bus.mood, m_mood); end
            n_checks++; if (bus.level_changed !== m_changed) begin n_fail++; $display("FAIL rnd_changed k=%0d got %0b exp %0b", k, bus.level_changed, m_changed); end
            n_checks++; if (bus.saturated !== ((m_level == 0) || (m_level == MAXV))) begin n_fail++; $display("FAIL rnd_saturated k=%0d got %0b level %0d", k, bus.saturated, m_level); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        test_reset();
        test_inc_to_top();
        test_hysteresis();
        test_decay();
        test_simultaneous();
        test_bottom();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
